// File: rtl/event_frame_binner_if.sv
// event_frame_binner_if
//   Bundles the event input handshake, frame output handshake and drop
//   counter of event_frame_binner.
//   slave  : the binner side (consumes events, produces frames)
//   master : the producer/consumer side (drives events, accepts frames)
//   in_timestamp_i/in_x_i/in_y_i/in_polarity_i/in_valid_i/in_ready_o : event stream
//   out_frame_o/out_window_o/out_valid_o/out_ready_i               : frame stream
//   drop_count_o                                                   : out-of-range events
interface event_frame_binner_if #(
  parameter int GRID    = 34,
  parameter int TS_W    = 34,
  parameter int COORD_W = 14,
  parameter int WIN_W   = 16
) ();
  logic [TS_W-1:0]        in_timestamp_i;
  logic [COORD_W-1:0]     in_x_i;
  logic [COORD_W-1:0]     in_y_i;
  logic                   in_polarity_i;
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [GRID*GRID*2-1:0] out_frame_o;
  logic [WIN_W-1:0]       out_window_o;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [15:0]            drop_count_o;

  modport slave (
    input  in_timestamp_i, in_x_i, in_y_i, in_polarity_i, in_valid_i, out_ready_i,
    output in_ready_o, out_frame_o, out_window_o, out_valid_o, drop_count_o
  );

  modport master (
    output in_timestamp_i, in_x_i, in_y_i, in_polarity_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_frame_o, out_window_o, out_valid_o, drop_count_o
  );
endinterface

// File: rtl/event_frame_binner.sv
// event_frame_binner
//   Bins DVS events (timestamp, x, y, polarity) into two-channel binary
//   occupancy frames on a GRID x GRID grid, one frame per TIME_WINDOW of
//   timestamp. A window closes only when a later event lands beyond it; that
//   event is held, the frame is presented, and the held event is replayed
//   into the next window (emitting empty frames for any skipped windows).
//   Ports:
//     clk_i   : clock
//     rst_ni  : asynchronous active-low reset
//     bus     : event_frame_binner_if.slave (event in, frame out, drop count)
module event_frame_binner #(
  parameter int MAX_X_COORD = 240,
  parameter int MAX_Y_COORD = 180,
  parameter int GRID        = 34,
  parameter int TIME_WINDOW = 100000,
  parameter int TS_W        = 34,
  parameter int COORD_W     = 14,
  parameter int WIN_W       = 16
) (
  input logic              clk_i,
  input logic              rst_ni,
  event_frame_binner_if.slave bus
);

  localparam int FRAME_W = GRID * GRID * 2;
  localparam int IDX_W   = $clog2(FRAME_W);
  localparam int GW      = $clog2(GRID + 1);
  localparam int PW      = COORD_W + GW;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_EMIT   = 2'd2;
  localparam logic [1:0] S_REPLAY = 2'd3;

  logic [1:0]         state_q;
  logic [FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0] out_frame_q;
  logic [TS_W-1:0]    ws_q;
  logic [TS_W-1:0]    hold_ts_q;
  logic [IDX_W-1:0]   hold_idx_q;
  logic [WIN_W-1:0]   win_q;
  logic [15:0]        drop_q;

  // Products are formed at full width so the floor division is exact.
  function automatic logic [IDX_W-1:0] cell_index(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y,
                                                  input logic pol);
    logic [PW-1:0] px, py, cx, cy, lin;
    px  = PW'(x) * PW'(GRID);
    py  = PW'(y) * PW'(GRID);
    cx  = px / PW'(MAX_X_COORD);
    cy  = py / PW'(MAX_Y_COORD);
    lin = (cy * PW'(GRID) + cx) * PW'(2) + PW'(pol);
    return lin[IDX_W-1:0];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [FRAME_W-1:0] bit_mask(input logic [IDX_W-1:0] idx);
    return FRAME_W'(1) << idx;
  endfunction

  logic             in_ready;
  logic             xfer;
  logic             in_range;
  logic [IDX_W-1:0] ev_idx;
  logic [TS_W:0]    win_end;
  logic             ev_late;
  logic             hold_late;

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_ACCUM);
  assign xfer      = bus.in_valid_i && in_ready;
  assign in_range  = (bus.in_x_i < COORD_W'(MAX_X_COORD)) &&
                     (bus.in_y_i < COORD_W'(MAX_Y_COORD));
  assign ev_idx    = cell_index(bus.in_x_i, bus.in_y_i, bus.in_polarity_i);
  assign win_end   = {1'b0, ws_q} + (TS_W+1)'(TIME_WINDOW);
  assign ev_late   = {1'b0, bus.in_timestamp_i} >= win_end;
  // Evaluated in REPLAY, after ws_q has already advanced by one window.
  assign hold_late = {1'b0, hold_ts_q} >= win_end;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      frame_q     <= '0;
      out_frame_q <= '0;
      ws_q        <= '0;
      hold_ts_q   <= '0;
      hold_idx_q  <= '0;
      win_q       <= '0;
      drop_q      <= '0;
    end else begin
      if (xfer && !in_range)
        drop_q <= sat_inc(drop_q);

      case (state_q)
        S_IDLE: begin
          if (xfer && in_range) begin
            ws_q    <= bus.in_timestamp_i;
            frame_q <= frame_q | bit_mask(ev_idx);
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (xfer && in_range) begin
            if (!ev_late) begin
              frame_q <= frame_q | bit_mask(ev_idx);
            end else begin
              hold_ts_q   <= bus.in_timestamp_i;
              hold_idx_q  <= ev_idx;
              out_frame_q <= frame_q;
              state_q     <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (bus.out_ready_i) begin
            frame_q <= '0;
            ws_q    <= ws_q + TS_W'(TIME_WINDOW);
            win_q   <= win_q + WIN_W'(1);
            state_q <= S_REPLAY;
          end
        end
        S_REPLAY: begin
          if (hold_late) begin
            out_frame_q <= frame_q;
            state_q     <= S_EMIT;
          end else begin
            frame_q <= frame_q | bit_mask(hold_idx_q);
            state_q <= S_ACCUM;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready_o   = in_ready;
  assign bus.out_frame_o  = out_frame_q;
  assign bus.out_window_o = win_q;
  assign bus.out_valid_o  = (state_q == S_EMIT);
  assign bus.drop_count_o = drop_q;

endmodule

// File: tb/tb_event_frame_binner.sv
// tb_event_frame_binner
//   Directed bench for event_frame_binner. A behavioural window model
//   predicts every frame when the closing event is driven; predictions are
//   queued and compared as the DUT presents frames.
module tb_event_frame_binner;

  localparam int MAXX = 240;
  localparam int MAXY = 180;
  localparam int GRID = 34;
  localparam longint TW = 100000;
  localparam int TS_W = 34;
  localparam int COORD_W = 14;
  localparam int WIN_W = 16;
  localparam int FW = GRID * GRID * 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  event_frame_binner_if #(.GRID(GRID), .TS_W(TS_W), .COORD_W(COORD_W), .WIN_W(WIN_W)) bus ();

  event_frame_binner #(
    .MAX_X_COORD(MAXX), .MAX_Y_COORD(MAXY), .GRID(GRID), .TIME_WINDOW(100000),
    .TS_W(TS_W), .COORD_W(COORD_W), .WIN_W(WIN_W)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] frame;
    int            win;
  } exp_t;

  exp_t exp_q[$];
  int n_total = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [FW-1:0] m_frame;
  longint        m_ws;
  bit            m_open;
  int            m_win;
  int            m_drops;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (fail #%0d)", tag, obs, exp, n_fail);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d bits set (low %0h) expected %0d bits set (low %0h) (fail #%0d)",
             tag, $countones(obs), obs[63:0], $countones(exp), exp[63:0], n_fail);
    end
  endtask

  function automatic int cell_bit(input int x, input int y, input int p);
    return (((y * GRID) / MAXY) * GRID + (x * GRID) / MAXX) * 2 + p;
  endfunction

  task automatic model_reset();
    m_frame = '0;
    m_ws    = 0;
    m_open  = 0;
    m_win   = 0;
    m_drops = 0;
    exp_q.delete();
  endtask

  task automatic push_exp(input logic [FW-1:0] f, input int w);
    exp_t e;
    e.frame = f;
    e.win   = w;
    exp_q.push_back(e);
  endtask

  task automatic model_event(input longint ts, input int x, input int y, input int p);
    int b;
    if (x >= MAXX || y >= MAXY) begin
      if (m_drops != 65535) m_drops++;
    end else begin
      b = cell_bit(x, y, p);
      if (!m_open) begin
        m_open = 1;
        m_ws = ts;
        m_frame[b] = 1'b1;
      end else if (ts < m_ws + TW) begin
        m_frame[b] = 1'b1;
      end else begin
        push_exp(m_frame, m_win);
        m_frame = '0;
        m_ws += TW;
        m_win = (m_win + 1) % 65536;
        while (ts >= m_ws + TW) begin
          push_exp('0, m_win);
          m_ws += TW;
          m_win = (m_win + 1) % 65536;
        end
        m_frame[b] = 1'b1;
      end
    end
  endtask

  task automatic send_event(input longint ts, input int x, input int y, input int p);
    int w;
    @(negedge clk);
    bus.in_timestamp_i = TS_W'(ts);
    bus.in_x_i         = COORD_W'(x);
    bus.in_y_i         = COORD_W'(y);
    bus.in_polarity_i  = p[0];
    bus.in_valid_i     = 1'b1;
    w = 0;
    while (bus.in_ready_o !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_at_xfer", 64'(bus.in_ready_o), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    model_event(ts, x, y, p);
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int w;
    w = 0;
    while (bus.out_valid_o !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("frame_valid", 64'(bus.out_valid_o), 64'd1);
    chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk_frame("frame", bus.out_frame_o, e.frame);
      chk("window", 64'(bus.out_window_o), 64'(e.win));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", 64'(bus.out_valid_o), 64'd1);
        chk("hold_in_ready", 64'(bus.in_ready_o), 64'd0);
        chk_frame("hold_frame", bus.out_frame_o, e.frame);
      end
      @(negedge clk);
      bus.out_ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready_i = 1'b0;
      chk("replay_in_ready", 64'(bus.in_ready_o), 64'd0);
      chk("replay_valid", 64'(bus.out_valid_o), 64'd0);
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) chk("empty_window_valid", 64'(bus.out_valid_o), 64'd1);
      else chk("accum_in_ready", 64'(bus.in_ready_o), 64'd1);
    end
  endtask

  logic [FW-1:0] f;

  initial begin
    bus.in_timestamp_i = '0;
    bus.in_x_i         = '0;
    bus.in_y_i         = '0;
    bus.in_polarity_i  = 1'b0;
    bus.in_valid_i     = 1'b0;
    bus.out_ready_i    = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
    chk("rst_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_drop", 64'(bus.drop_count_o), 64'd0);
    chk("rst_window", 64'(bus.out_window_o), 64'd0);
    chk_frame("rst_frame", bus.out_frame_o, '0);
    rst_n = 1'b1;

    // Out-of-range event: counted, no window opened
    send_event(50, 240, 0, 0);
    chk("drop_count", 64'(bus.drop_count_o), 64'(m_drops));
    chk("drop_no_valid", 64'(bus.out_valid_o), 64'd0);

    // Binning window 0
    send_event(10, 0, 0, 1);
    send_event(10, 120, 90, 0);
    send_event(100010, 5, 5, 0);
    chk("bin_valid_next_cycle", 64'(bus.out_valid_o), 64'd1);
    f = '0;
    f[1] = 1'b1;
    f[1190] = 1'b1;
    chk_frame("bin_frame_const", bus.out_frame_o, f);
    collect(0);

    // Window 1: both polarities, repeat, corner cell; backpressure on emit
    send_event(100020, 120, 90, 0);
    send_event(100030, 120, 90, 1);
    send_event(100040, 120, 90, 1);
    send_event(100050, 239, 179, 1);
    send_event(200010, 0, 0, 0);
    f = '0;
    f[0] = 1'b1;
    f[1190] = 1'b1;
    f[1191] = 1'b1;
    f[2311] = 1'b1;
    chk_frame("pol_corner_frame_const", bus.out_frame_o, f);
    chk("pol_window", 64'(bus.out_window_o), 64'd1);
    collect(20);

    // Reset while a frame is presented
    send_event(300010, 1, 1, 0);
    chk("pre_reset_valid", 64'(bus.out_valid_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_valid_drop", 64'(bus.out_valid_o), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready_o), 64'd1);
    chk_frame("reset_frame", bus.out_frame_o, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Empty windows: ws = 7, next event 3.5 windows later
    send_event(7, 0, 0, 1);
    send_event(350007, 120, 90, 1);
    chk("empty_first_window", 64'(bus.out_window_o), 64'd0);
    collect(0);
    collect(0);
    collect(0);
    send_event(400007, 0, 0, 0);
    f = '0;
    f[1191] = 1'b1;
    chk_frame("held_lands_frame_const", bus.out_frame_o, f);
    chk("held_lands_window", 64'(bus.out_window_o), 64'd3);
    collect(0);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
